div_tick_pwm: RTL
=================

// Module: div_tick_pwm
// PURPOSE
//  Downstream consumer of the divided clock from the clock divider. Samples the divided
//  clock div_in in the clk domain and turns each div_in rising edge into a one-cycle tick.
//  Ticks drive a configurable PWM generator. Period/duty configuration uses a valid/ready
//  handshake and is double-buffered, so new settings take effect only at a period boundary.
// PARAMETERS
//  CNT_W   8   width of the period and duty fields and of the tick counter
// PORTS
//  clk          in   1      system clock; div_in is generated synchronously from it
//  rst          in   1      asynchronous, active-high reset
//  div_in       in   1      divided clock level from the clock divider
//  en           in   1      run request
//  cfg_valid    in   1      configuration offered
//  cfg_ready    out  1      configuration accepted when cfg_valid and cfg_ready are both 1
//  cfg_period   in   CNT_W  PWM period in ticks; 0 is clamped to 1
//  cfg_duty     in   CNT_W  ticks high per period; 0 = always low, >= period = always high
//  tick         out  1      one-cycle pulse, one clk after each div_in rising edge
//  pwm_out      out  1      PWM output
//  period_done  out  1      one-cycle pulse at each period wrap
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset (async): div_q=0, tick=0, cnt=0, state=IDLE, act_vld=0, pend_vld=0,
//    pwm_out=0, period_done=0, busy=0, cfg_ready=1.
//  Edge detect: div_q<=div_in; tick<=div_in & ~div_q (registered, latency 1 clk).
//    If div_in is 1 in the first cycle after reset, one tick is produced (by design).
//  Config:
//    cfg_ready = ~pend_vld.
//    In IDLE, an accepted config writes act_period/act_duty directly and sets act_vld=1.
//    In RUN or DRAIN, an accepted config is stored in the pending registers and sets
//      pend_vld=1.
//    Stored period = (cfg_period==0) ? 1 : cfg_period.
//  FSM:
//    IDLE  -> RUN  when en & act_vld; cnt=0.
//    RUN   -> DRAIN when ~en.
//    DRAIN -> RUN  when en is reasserted before the period end; cnt is unchanged.
//    DRAIN -> IDLE at the period end.
//  Counting (RUN/DRAIN only):
//    On tick, if cnt==act_period-1 this is the period end: cnt<=0, period_done<=1.
//      If pend_vld, the pending values are copied to active and pend_vld<=0.
//    On tick otherwise: cnt<=cnt+1.
//    Without a tick, cnt holds. The counter never exceeds act_period-1 and never wraps
//      modulo 2^CNT_W.
//  pwm_out = (state!=IDLE) & (cnt < act_duty), decoded from registers only.
//    pwm_out is 0 in IDLE.
//  Simultaneous events:
//    A config accepted in the same cycle as a period end goes to pending and applies at
//      the next boundary, not the current one.
//    If ~en and the period end occur in the same cycle in RUN, the block goes to DRAIN
//      (it does not skip to IDLE). The new period then runs to its end.
//  rst during operation forces all reset values immediately. Active and pending configs
//    are discarded.
// TESTING
//  Bench drives div_in toggling every 4 clk (one tick per 8 clk).
//  1) rst; cfg P=4 D=1; en=1 -> tick every 8 clk; pwm_out high 8 clk, low 24 clk;
//     period_done every 32 clk.
//  2) cfg P=4 D=0 -> pwm_out stays 0. Then cfg P=4 D=5 (after a boundary) -> pwm_out
//     stays 1 while running.
//  3) Running P=4 D=2; at cnt=1 send P=2 D=1 -> cfg_ready=0 until wrap; afterwards
//     period_done every 16 clk, pwm_out high 8 clk.
//  4) en=0 at cnt=1 -> busy=1 until period_done, then IDLE, pwm_out=0.
//     Repeat with en=1 again at cnt=2 -> stays RUN, cnt continues 2->3->0.
//  5) rst pulse at cnt=2 mid-run -> all outputs 0 in the same cycle, cfg_ready=1.
//     en=1 with no new cfg -> stays IDLE.
//  6) cfg P=0 D=1 -> treated as P=1: period_done on every tick, pwm_out constant 1.

Source files
------------

// File: rtl/div_tick_pwm.sv
// div_tick_pwm: turns rising edges of the divided clock into one-cycle ticks
// and drives a tick-counted PWM generator. The period/duty configuration is
// double-buffered and only switches at a period boundary while running.
module div_tick_pwm #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             tick,
  output logic             pwm_out,
  output logic             period_done,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic             div_q;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             period_done_q, period_done_d;
  logic             act_vld_q, act_vld_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_duty_q, act_duty_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d;
  logic [CNT_W-1:0] pend_duty_q, pend_duty_d;

  logic             running;
  logic             cfg_acc;
  logic             wrap;
  logic [CNT_W-1:0] cfg_period_clamped;

  assign running            = (state_q != IDLE);
  assign cfg_acc            = cfg_valid & ~pend_vld_q;
  assign cfg_period_clamped = (cfg_period == '0) ? ONE : cfg_period;
  // act_period is never 0, so act_period-1 cannot underflow
  assign wrap               = running & tick_q & (cnt_q == (act_period_q - ONE));
  assign tick_d             = div_in & ~div_q;

  // Next-state logic for the FSM, tick counter and configuration buffers
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    period_done_d = 1'b0;
    act_vld_d     = act_vld_q;
    act_period_d  = act_period_q;
    act_duty_d    = act_duty_q;
    pend_vld_d    = pend_vld_q;
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;

    if (!running) begin
      if (cfg_acc) begin
        act_period_d = cfg_period_clamped;
        act_duty_d   = cfg_duty;
        act_vld_d    = 1'b1;
      end
    end else begin
      if (tick_q) begin
        if (wrap) begin
          cnt_d         = '0;
          period_done_d = 1'b1;
          if (pend_vld_q) begin
            act_period_d = pend_period_q;
            act_duty_d   = pend_duty_q;
            pend_vld_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      // cfg_acc requires pend_vld_q==0, so it never collides with the copy above
      if (cfg_acc) begin
        pend_period_d = cfg_period_clamped;
        pend_duty_d   = cfg_duty;
        pend_vld_d    = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (en && act_vld_q) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!en) state_d = DRAIN;
      end
      DRAIN: begin
        if (wrap)    state_d = IDLE;
        else if (en) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      div_q         <= 1'b0;
      tick_q        <= 1'b0;
      cnt_q         <= '0;
      period_done_q <= 1'b0;
      act_vld_q     <= 1'b0;
      act_period_q  <= '0;
      act_duty_q    <= '0;
      pend_vld_q    <= 1'b0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_in;
      tick_q        <= tick_d;
      cnt_q         <= cnt_d;
      period_done_q <= period_done_d;
      act_vld_q     <= act_vld_d;
      act_period_q  <= act_period_d;
      act_duty_q    <= act_duty_d;
      pend_vld_q    <= pend_vld_d;
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
    end
  end

  assign tick        = tick_q;
  assign period_done = period_done_q;
  assign busy        = running;
  assign cfg_ready   = ~pend_vld_q;
  assign pwm_out     = running & (cnt_q < act_duty_q);

endmodule
